mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-stage accesses onto a single fixed-latency memory port.
// Data requests normally win; a streak limit makes sure a waiting fetch is not starved.
module mem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  // state  | meaning
  // IDLE   | no access outstanding; arbitrate pending requests
  // BUSY_I | fetch access in flight, counting down memory latency
  // BUSY_D | data access in flight, counting down memory latency
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] DMAX = 4'(MAX_DSTREAK);

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [3:0]        dstreak;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              grant_d;
  logic              grant_i;

  assign grant_d = dm_req & ~(if_req & (dstreak == DMAX));
  assign grant_i = if_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      dstreak   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            lat_addr  <= dm_addr;
            lat_we    <= dm_we;
            lat_wdata <= dm_wdata;
            mem_en    <= 1'b1;
            lat_cnt   <= LAT;
            if (!if_req)
              dstreak <= '0;
            else if (dstreak != DMAX)
              dstreak <= dstreak + 4'd1;
          end else if (grant_i) begin
            state     <= BUSY_I;
            lat_addr  <= if_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            mem_en    <= 1'b1;
            lat_cnt   <= LAT;
            dstreak   <= '0;
          end else begin
            dstreak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // ready is registered one count early so it lands in the response cycle
          if (lat_cnt == 3'd1) begin
            if_ready <= (state == BUSY_I);
            dm_ready <= (state == BUSY_D);
          end
          if (lat_cnt == 3'd0)
            state <= IDLE;
          else
            lat_cnt <= lat_cnt - 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign dm_rdata  = dm_ready ? mem_rdata : '0;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule
